// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, synchronous-ROM issue, 2-entry output queue, branch redirect/flush.
// Optional FETCH_PERF_CNT_EN adds a saturating 16-bit flush_cnt of accepted redirects.
module fetch_stage #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    IMM_LENGTH  = 12,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    PC_INC      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_en,
    output logic [DATA_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0]  instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    input  logic                   redirect,
    input  logic [IMM_LENGTH-1:0]  redirect_off
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]            flush_cnt
`endif
);

    logic [DATA_WIDTH-1:0]  pc_q, f_pc, skid_pc, target;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [1:0]             occ, occ_d;
    logic [2:0]             level;
    logic                   inflight, pop, flush, push;
    logic                   head_ld, head_from_skid, skid_ld;

    assign pop       = instr_valid & instr_ready;
    assign flush     = pop & redirect;
    assign push      = inflight & ~flush;
    assign imem_addr = pc_q;
    assign target    = instr_pc + {{(DATA_WIDTH-IMM_LENGTH){redirect_off[IMM_LENGTH-1]}}, redirect_off};

    // Occupancy once this cycle's pop and pending return settle; issuing below 2 can never overflow.
    assign level   = {1'b0, occ} - {2'b0, pop} + {2'b0, inflight};
    assign imem_en = rst_n & ~flush & (level < 3'd2);

    always_comb begin
        occ_d          = occ;
        head_ld        = 1'b0;
        head_from_skid = 1'b0;
        skid_ld        = 1'b0;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            case (occ)
                2'd0: if (push) begin
                    occ_d   = 2'd1;
                    head_ld = 1'b1;
                end
                2'd1: begin
                    if (push && pop) begin
                        head_ld = 1'b1;
                    end else if (pop) begin
                        occ_d = 2'd0;
                    end else if (push) begin
                        skid_ld = 1'b1;
                        occ_d   = 2'd2;
                    end
                end
                default: if (pop) begin
                    head_ld        = 1'b1;
                    head_from_skid = 1'b1;
                    if (push) skid_ld = 1'b1;
                    else      occ_d   = 2'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            f_pc        <= '0;
            inflight    <= 1'b0;
            occ         <= 2'd0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
        end else begin
            if (flush)        pc_q <= target;
            else if (imem_en) pc_q <= pc_q + DATA_WIDTH'(PC_INC);
            if (imem_en) f_pc <= pc_q;
            inflight    <= imem_en;
            occ         <= occ_d;
            instr_valid <= (occ_d != 2'd0);
            if (head_ld) begin
                instr    <= head_from_skid ? skid_instr : imem_rdata;
                instr_pc <= head_from_skid ? skid_pc    : f_pc;
            end
            if (skid_ld) begin
                skid_instr <= imem_rdata;
                skid_pc    <= f_pc;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          flush_cnt <= 16'd0;
        else if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall, redirects, PC wrap and mid-stream reset.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Main instance, RESET_PC = 0
    logic        rst_n, imem_en, instr_valid, instr_ready, redirect;
    logic [31:0] imem_addr, instr, instr_pc;
    logic [31:0] imem_rdata = '0;
    logic [11:0] redirect_off;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] flush_cnt;
`endif

    // Wrap instance, RESET_PC = 0xFFFFFFF8
    logic        w_rst_n, w_imem_en, w_valid, w_ready, w_redirect;
    logic [31:0] w_addr, w_instr, w_pc;
    logic [31:0] w_rdata = '0;
    logic [11:0] w_off;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] w_flush_cnt;
`endif

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_off(redirect_off)
`ifdef FETCH_PERF_CNT_EN
        , .flush_cnt(flush_cnt)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .rst_n(w_rst_n), .imem_en(w_imem_en), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .instr(w_instr), .instr_pc(w_pc),
        .instr_valid(w_valid), .instr_ready(w_ready),
        .redirect(w_redirect), .redirect_off(w_off)
`ifdef FETCH_PERF_CNT_EN
        , .flush_cnt(w_flush_cnt)
`endif
    );

    // ROM[i] = 0x100 + i, word index taken from address bits [9:2]
    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h100 + {24'd0, a[9:2]};
    endfunction

    always @(posedge clk) if (imem_en)   imem_rdata <= rom(imem_addr);
    always @(posedge clk) if (w_imem_en) w_rdata    <= rom(w_addr);

    // A return arriving into a full queue with no pop would be an overflow.
    always @(negedge clk)
        if (rst_n && dut.occ == 2'd2 && dut.inflight && !(instr_valid && instr_ready)) begin
            n_err++;
            $display("FAIL overflow: observed push into full queue, expected none");
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_pc"}, instr_pc, pc);
        chk({tag, "_instr"}, instr, ins);
    endtask

    initial begin
        rst_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_off = '0;
        w_rst_n = 1'b0; w_ready = 1'b1; w_redirect = 1'b0; w_off = '0;
        #2;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_imem_en", {31'd0, imem_en}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // Streaming from reset release
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rel_imem_en", {31'd0, imem_en}, 32'd1);
        step();
        chk("edge1_valid", {31'd0, instr_valid}, 32'd0);
        step(); chk_out("s0", 32'd0, 32'h100);
        step(); chk_out("s1", 32'd4, 32'h101);
        step(); chk_out("s2", 32'd8, 32'h102);

        // Stall at pc 8 for 5 cycles
        instr_ready = 1'b0;
        #1;
        chk("stall_en0", {31'd0, imem_en}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("stall_hold", 32'd8, 32'h102);
            chk("stall_en", {31'd0, imem_en}, 32'd0);
        end
        instr_ready = 1'b1;
        #1;
        chk_out("rel8", 32'd8, 32'h102);
        step(); chk_out("rel12", 32'd12, 32'h103);
        step(); chk_out("rel16", 32'd16, 32'h104);
        step(); chk_out("rel20", 32'd20, 32'h105);

        // Redirect +16 at instr_pc 8
        rst_n = 1'b0; #2; rst_n = 1'b1;
        step(); step(); chk_out("b0", 32'd0, 32'h100);
        step(); chk_out("b4", 32'd4, 32'h101);
        step(); chk_out("b8", 32'd8, 32'h102);
        redirect = 1'b1; redirect_off = 12'h010;
        #1;
        chk("redir_en", {31'd0, imem_en}, 32'd0);
        step(); redirect = 1'b0;
        chk("bub1", {31'd0, instr_valid}, 32'd0);
        step(); chk("bub2", {31'd0, instr_valid}, 32'd0);
        step(); chk_out("tgt24", 32'd24, 32'h106);

        // Redirect with instr_ready=0 is ignored
        instr_ready = 1'b0; redirect = 1'b1; redirect_off = 12'hFF8;
        step(); chk_out("ign24", 32'd24, 32'h106);

        // Redirect -4 at 24 -> 20, then -8 at 20 -> 12
        instr_ready = 1'b1; redirect_off = 12'hFFC;
        step(); redirect = 1'b0;
        chk("bub3", {31'd0, instr_valid}, 32'd0);
        step(); chk("bub4", {31'd0, instr_valid}, 32'd0);
        step(); chk_out("tgt20", 32'd20, 32'h105);
        redirect = 1'b1; redirect_off = 12'hFF8;
        step(); redirect = 1'b0;
        chk("bub5", {31'd0, instr_valid}, 32'd0);
        step(); chk("bub6", {31'd0, instr_valid}, 32'd0);
        step(); chk_out("tgt12", 32'd12, 32'h103);
        step(); chk_out("tgt16", 32'd16, 32'h104);
`ifdef FETCH_PERF_CNT_EN
        chk("flush_cnt", {16'd0, flush_cnt}, 32'd3);
`endif

        // PC wrap on the second instance
        w_rst_n = 1'b1;
        step(); chk("w_edge1", {31'd0, w_valid}, 32'd0);
        step(); chk("w_pc0", w_pc, 32'hFFFF_FFF8); chk("w_i0", w_instr, 32'h1FE);
        step(); chk("w_pc1", w_pc, 32'hFFFF_FFFC); chk("w_i1", w_instr, 32'h1FF);
        step(); chk("w_pc2", w_pc, 32'h0);         chk("w_i2", w_instr, 32'h100);

        // Mid-stream reset pulse
        w_rst_n = 1'b0;
        #1;
        chk("w_rst_valid", {31'd0, w_valid}, 32'd0);
        chk("w_rst_en", {31'd0, w_imem_en}, 32'd0);
        chk("w_rst_addr", w_addr, 32'hFFFF_FFF8);
        #1; w_rst_n = 1'b1;
        step(); chk("w_re_edge1", {31'd0, w_valid}, 32'd0);
        step(); chk("w_re_pc", w_pc, 32'hFFFF_FFF8); chk("w_re_i", w_instr, 32'h1FE);
        step(); chk("w_re_pc1", w_pc, 32'hFFFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage. Sits directly upstream of the register-file/ALU execute datapath.
- Owns the program counter and drives a synchronous instruction ROM.
- Buffers fetched instructions in a 2-entry output queue with a valid/ready handshake.
- Accepts a PC-relative branch redirect computed downstream (EQ-based branch decision) and flushes wrong-path fetches.

Parameters:
- DATA_WIDTH, 32, PC and address width.
- INSTR_WIDTH, 32, instruction word width.
- IMM_LENGTH, 12, branch offset width (two's complement, byte offset).
- RESET_PC, 0, PC value loaded on reset.
- PC_INC, 4, PC increment per sequential fetch.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_en  output  1  fetch issue strobe to ROM.
- imem_addr  output  DATA_WIDTH  fetch address (= pc_q).
- imem_rdata  input  INSTR_WIDTH  ROM data, valid the cycle after an issue.
- instr  output  INSTR_WIDTH  head-of-queue instruction.
- instr_pc  output  DATA_WIDTH  PC of instr.
- instr_valid  output  1  head entry valid.
- instr_ready  input  1  downstream accepts head this cycle.
- redirect  input  1  branch taken; sampled only on a handshake cycle.
- redirect_off  input  IMM_LENGTH  signed offset relative to instr_pc.

Behaviour:
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, queue occupancy occ=0, inflight=0.
  - instr=0, instr_pc=0, instr_valid=0.
  - imem_en forced 0 while rst_n=0.
- Handshake:
  - pop = instr_valid & instr_ready.
  - instr, instr_pc and instr_valid are registered outputs, stable while instr_valid=1 and instr_ready=0.
- Issue rule, combinational: imem_en = rst_n & ((occ - pop + inflight) < 2). On issue: inflight<=1, f_pc<=pc_q, pc_q<=pc_q+PC_INC.
- PC arithmetic:
  - pc_q wraps modulo 2^DATA_WIDTH with no flag.
  - redirect_off is sign-extended to DATA_WIDTH.
- Return: in the cycle after an issue, imem_rdata/f_pc are pushed into the queue (head if empty, else skid entry).
- Latency: issue to instr_valid = 2 cycles. First instr_valid is the 2nd rising edge after rst_n deasserts.
- Throughput: 1 instruction/cycle sustained when instr_ready=1.
- Queue states:
  - EMPTY (occ=0), ONE (occ=1), FULL (occ=2).
  - Push and pop in the same cycle keeps occ; the skid entry moves to head on pop.
  - FULL with no pop: imem_en=0. No push can arrive, because the issue rule prevents it.
  - The issue rule guarantees no overflow. Overflow is unreachable; the bench asserts it never happens.
- Redirect:
  - Acts only when pop=1 & redirect=1. redirect without pop is ignored.
  - Action: pc_q <= instr_pc + sext(redirect_off). Queue cleared (occ<=0). The in-flight return is discarded (inflight<=0). imem_en=0 in the redirect cycle.
  - Target issued the next cycle; target instr_valid 2 cycles after that. Branch penalty = 2 bubble cycles.
  - Redirect takes priority over push and issue in the same cycle.
- Reset mid-operation: everything returns immediately to reset values. ROM data returning after reset release is ignored (inflight=0).
- Misaligned targets are not checked; the PC is used as computed.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output flush_cnt (16 bits). It increments by 1 on each accepted redirect, saturates at 0xFFFF, and resets to 0.
- Undefined: port absent, no counter logic; all other behaviour identical.

Test Plan:
- Reset release, ROM[i]=0x100+i, instr_ready=1:
  - instr_valid rises at edge 2.
  - Outputs (pc, instr) = (0,0x100), (4,0x101), (8,0x102) on consecutive cycles, with no gaps.
- Stall: instr_ready=0 for 5 cycles at pc=8:
  - instr=0x102/instr_pc=8 held.
  - occ reaches 2, imem_en=0 after that.
  - On release, pcs 8, 12, 16 come out back-to-back with no loss or duplication.
- Redirect +16 accepted at instr_pc=8:
  - Next valid instr_pc=24 after exactly 2 bubble cycles.
  - Wrong-path pc 12 never appears.
- Redirect -8 (redirect_off=0xFF8) at instr_pc=20 gives next instr_pc=12. redirect=1 with instr_ready=0 has no effect.
- RESET_PC=0xFFFFFFF8: pcs 0xFFFFFFF8, 0xFFFFFFFC, 0x0 wrap correctly. rst_n pulsed low mid-stream: instr_valid drops the same cycle and fetch restarts at RESET_PC.
- With FETCH_PERF_CNT_EN defined: 3 accepted redirects plus 1 ignored redirect gives flush_cnt=3.
